param_bank_loader: RTL and testbench

PARAM_BANK_LOADER -- requirements
Module: param_bank_loader

---
 rtl/param_bank_loader_if.sv | 26 ++
 rtl/param_bank_loader.sv | 132 +++++++++++++
 tb/tb_param_bank_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_bank_loader_if.sv
// Write/commit bus for param_bank_loader.
//   master drives: wr_en, wr_field, wr_data, commit_req, frame_tick
//   slave drives : wr_ready
interface param_bank_loader_if #(
  parameter int unsigned NFIELD = 3,
  parameter int unsigned W      = 16
);
  localparam int unsigned FW = (NFIELD > 1) ? $clog2(NFIELD) : 1;

  logic          wr_en;
  logic [FW-1:0] wr_field;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          commit_req;
  logic          frame_tick;

  modport master (
    output wr_en, wr_field, wr_data, commit_req, frame_tick,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_field, wr_data, commit_req, frame_tick,
    output wr_ready
  );
endinterface

// File: rtl/param_bank_loader.sv
// Double-buffered parameter bank. Words are streamed into a shadow bank one
// field at a time; a commit request arms a swap that copies shadow to active
// on the next frame tick.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   clear          : synchronous functional clear of banks and flags
//   bus (slave)    : write strobe/field/data, wr_ready, commit_req, frame_tick
//   active_out     : active bank, field f channel c at [(f*NCH+c)*W +: W]
//   field_full     : bit f set when field f has received NCH words
//   commit_pending, commit_done, overflow, commit_reject : status
module param_bank_loader #(
  parameter int unsigned NCH          = 64,
  parameter int unsigned W            = 16,
  parameter int unsigned NFIELD       = 3,
  parameter int unsigned REQUIRE_FULL = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  param_bank_loader_if.slave        bus,
  output logic [NFIELD*NCH*W-1:0]   active_out,
  output logic [NFIELD-1:0]         field_full,
  output logic                      commit_pending,
  output logic                      commit_done,
  output logic                      overflow,
  output logic                      commit_reject
);

  localparam int unsigned BW  = NFIELD * NCH * W;
  localparam int unsigned BIW = $clog2(BW);
  localparam int unsigned PW  = $clog2(NCH + 1);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  shadow_q, shadow_d;
  logic [BW-1:0]  active_q, active_d;
  logic [PW-1:0]  ptr_q [NFIELD];
  logic [PW-1:0]  ptr_d [NFIELD];
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           rej_q, rej_d;

  logic [NFIELD-1:0] full_c;
  logic              fld_ok_c;
  logic [PW-1:0]     wptr_c;
  logic [BIW-1:0]    wbase_c;

  // Per-field full flags and the write slot addressed by the current word.
  always_comb begin
    for (int unsigned f = 0; f < NFIELD; f++) begin
      full_c[f] = (ptr_q[f] == PW'(NCH));
    end
    fld_ok_c = (32'(bus.wr_field) < NFIELD);
    wptr_c   = fld_ok_c ? ptr_q[bus.wr_field] : '0;
    wbase_c  = BIW'((32'(bus.wr_field) * NCH + 32'(wptr_c)) * W);
  end

  // Next-state: clear > swap > commit_req > write.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    rej_d    = rej_q;

    if (clear) begin
      state_d  = ST_IDLE;
      shadow_d = '0;
      active_d = '0;
      for (int unsigned f = 0; f < NFIELD; f++) ptr_d[f] = '0;
      ovf_d    = 1'b0;
      rej_d    = 1'b0;
    end else begin
      case (state_q)
        ST_PEND: begin
          // Writes and further requests are locked out until the swap.
          if (bus.frame_tick) begin
            active_d = shadow_q;
            for (int unsigned f = 0; f < NFIELD; f++) ptr_d[f] = '0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          if (bus.commit_req) begin
            if ((REQUIRE_FULL != 0) && !(&full_c)) rej_d = 1'b1;
            else state_d = ST_PEND;
          end
          if (bus.wr_en) begin
            if (!fld_ok_c || (wptr_c == PW'(NCH))) begin
              ovf_d = 1'b1;
            end else begin
              shadow_d[wbase_c +: W]  = bus.wr_data;
              ptr_d[bus.wr_field]     = wptr_c + PW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      for (int unsigned f = 0; f < NFIELD; f++) ptr_q[f] <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      rej_q    <= rej_d;
    end
  end

  assign bus.wr_ready    = (state_q == ST_IDLE);
  assign active_out      = active_q;
  assign field_full      = full_c;
  assign commit_pending  = (state_q == ST_PEND);
  assign commit_done     = done_q;
  assign overflow        = ovf_q;
  assign commit_reject   = rej_q;

endmodule

// File: tb/tb_param_bank_loader.sv
// Randomized scoreboard bench for param_bank_loader (NCH=4, W=16, NFIELD=3),
// plus a second instance with REQUIRE_FULL=1 for the commit-reject path.
module tb_param_bank_loader;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned NF  = 3;
  localparam int unsigned BW  = NF * NCH * W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr_m = 1'b0;
  logic clr_f = 1'b0;

  always #5 clk = ~clk;

  param_bank_loader_if #(.NFIELD(NF), .W(W)) bm ();
  param_bank_loader_if #(.NFIELD(NF), .W(W)) bf ();

  logic [BW-1:0] act_m, act_f;
  logic [NF-1:0] ff_m, ff_f;
  logic pend_m, done_m, ovf_m, rej_m;
  logic pend_f, done_f, ovf_f, rej_f;

  param_bank_loader #(.NCH(NCH), .W(W), .NFIELD(NF), .REQUIRE_FULL(0)) u_dut (
    .clk(clk), .reset(reset), .clear(clr_m), .bus(bm),
    .active_out(act_m), .field_full(ff_m), .commit_pending(pend_m),
    .commit_done(done_m), .overflow(ovf_m), .commit_reject(rej_m)
  );

  param_bank_loader #(.NCH(NCH), .W(W), .NFIELD(NF), .REQUIRE_FULL(1)) u_full (
    .clk(clk), .reset(reset), .clear(clr_f), .bus(bf),
    .active_out(act_f), .field_full(ff_f), .commit_pending(pend_f),
    .commit_done(done_f), .overflow(ovf_f), .commit_reject(rej_f)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: shadow words, fill counts, flags and the active image.
  logic [W-1:0]  m_sh [NF][NCH];
  int            m_cnt [NF];
  bit            m_pend, m_ovf, m_done;
  logic [BW-1:0] m_act;
  logic [BW-1:0] sb_q [$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] image();
    logic [BW-1:0] v = '0;
    for (int f = 0; f < int'(NF); f++)
      for (int c = 0; c < int'(NCH); c++)
        v[(f*NCH+c)*W +: W] = m_sh[f][c];
    return v;
  endfunction

  function automatic logic [NF-1:0] model_full();
    logic [NF-1:0] v;
    for (int f = 0; f < int'(NF); f++) v[f] = (m_cnt[f] == int'(NCH));
    return v;
  endfunction

  task automatic model_zero();
    for (int f = 0; f < int'(NF); f++) begin
      m_cnt[f] = 0;
      for (int c = 0; c < int'(NCH); c++) m_sh[f][c] = '0;
    end
    m_pend = 0; m_ovf = 0; m_done = 0; m_act = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    chk("wr_ready", BW'(bm.wr_ready), BW'(!m_pend));
    chk("commit_pending", BW'(pend_m), BW'(m_pend));
    chk("commit_done", BW'(done_m), BW'(m_done));
    chk("overflow", BW'(ovf_m), BW'(m_ovf));
    chk("commit_reject", BW'(rej_m), '0);
    chk("field_full", BW'(ff_m), BW'(model_full()));
    chk("active_out", act_m, m_act);
  endtask

  // One clock on the main instance with the model advanced alongside.
  task automatic cycle(input bit we, input int f, input logic [W-1:0] d, input bit cr, input bit ft);
    bm.wr_en = we; bm.wr_field = 2'(f); bm.wr_data = d;
    bm.commit_req = cr; bm.frame_tick = ft;
    m_done = 0;
    if (m_pend) begin
      if (ft) begin
        m_act = image();
        sb_q.push_back(m_act);
        for (int i = 0; i < int'(NF); i++) m_cnt[i] = 0;
        m_pend = 0;
        m_done = 1;
      end
    end else begin
      if (cr) m_pend = 1;
      if (we) begin
        if (f >= int'(NF) || m_cnt[f] == int'(NCH)) m_ovf = 1;
        else begin
          m_sh[f][m_cnt[f]] = d;
          m_cnt[f]++;
        end
      end
    end
    step();
    bm.wr_en = 0; bm.commit_req = 0; bm.frame_tick = 0;
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_zero();
    sb_q.delete();
    check_state();
  endtask

  task automatic do_clear();
    clr_m = 1'b1;
    model_zero();
    step();
    clr_m = 1'b0;
    check_state();
  endtask

  task automatic fcycle(input bit we, input int f, input logic [W-1:0] d, input bit cr, input bit ft);
    bf.wr_en = we; bf.wr_field = 2'(f); bf.wr_data = d;
    bf.commit_req = cr; bf.frame_tick = ft;
    step();
    bf.wr_en = 0; bf.commit_req = 0; bf.frame_tick = 0;
  endtask

  // Scoreboard monitor: every commit_done must match the oldest expected image.
  always @(negedge clk) begin
    if (!reset && done_m) begin
      if (sb_q.size() == 0) chk("unexpected_commit_done", BW'(1), '0);
      else chk("sb_active_on_done", act_m, sb_q.pop_front());
    end
  end

  initial begin
    logic [W-1:0] w5 [5];
    bm.wr_en = 0; bm.wr_field = '0; bm.wr_data = '0; bm.commit_req = 0; bm.frame_tick = 0;
    bf.wr_en = 0; bf.wr_field = '0; bf.wr_data = '0; bf.commit_req = 0; bf.frame_tick = 0;
    model_zero();

    do_reset();
    chk("full_reset_active", act_f, '0);
    chk("full_reset_ready", BW'(bf.wr_ready), BW'(1));

    // Basic load, commit, tick three cycles later.
    for (int c = 0; c < 4; c++) cycle(1, 1, 16'((c + 1) * 17), 0, 0);
    cycle(1, 0, 16'hAAAA, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 1);
    chk("done_after_tick", BW'(done_m), BW'(1));
    for (int c = 0; c < 4; c++) chk("f1_word", BW'(act_m[(4+c)*16 +: 16]), BW'(16'((c + 1) * 17)));
    chk("f0c0_word", BW'(act_m[15:0]), BW'(16'hAAAA));
    chk("f0_rest_zero", BW'(act_m[63:16]), '0);
    chk("f2_zero", BW'(act_m[191:128]), '0);
    chk("ptrs_zero", BW'(ff_m), '0);
    cycle(0, 0, '0, 0, 0);
    chk("done_one_cycle", BW'(done_m), '0);

    // Second commit rewriting only field0 ch0.
    cycle(1, 0, 16'h1234, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 1);
    chk("recommit_f0c0", BW'(act_m[15:0]), BW'(16'h1234));
    for (int c = 0; c < 4; c++) chk("f1_retained", BW'(act_m[(4+c)*16 +: 16]), BW'(16'((c + 1) * 17)));

    // Five writes into a four-entry field.
    for (int i = 0; i < 5; i++) begin
      w5[i] = 16'($urandom);
      cycle(1, 2, w5[i], 0, 0);
    end
    chk("f2_full", BW'(ff_m[2]), BW'(1));
    chk("overflow_set", BW'(ovf_m), BW'(1));
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 1);
    for (int c = 0; c < 4; c++) chk("f2_first_four", BW'(act_m[(8+c)*16 +: 16]), BW'(w5[c]));

    // Writes during a pending commit are dropped silently.
    do_clear();
    cycle(1, 0, 16'h5555, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(1, 0, 16'h7777, 0, 0);
    chk("ready_low_pending", BW'(bm.wr_ready), '0);
    cycle(1, 3, 16'h8888, 0, 0);
    chk("no_ovf_pending", BW'(ovf_m), '0);
    cycle(0, 0, '0, 0, 1);
    chk("pend_f0c0", BW'(act_m[15:0]), BW'(16'h5555));
    chk("pend_f0c1_unwritten", BW'(act_m[31:16]), '0);

    // Request and tick together: no swap on that same tick.
    cycle(1, 1, 16'h0BAD, 0, 0);
    cycle(0, 0, '0, 1, 1);
    chk("same_cycle_no_done", BW'(done_m), '0);
    cycle(0, 0, '0, 0, 1);

    // Reset abandons a pending commit.
    cycle(1, 0, 16'h9999, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 0);
    do_reset();
    cycle(0, 0, '0, 0, 1);
    chk("abandon_active_zero", act_m, '0);
    chk("abandon_no_pending", BW'(pend_m), '0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 2) do_clear();
      else begin
        bit we = (r < 65);
        bit cr = (r >= 65 && r < 77);
        bit ft = ($urandom_range(0, 3) == 0);
        int f  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        cycle(we, f, 16'($urandom), cr, ft);
      end
    end
    cycle(0, 0, '0, 0, 0);
    chk("scoreboard_drained", BW'(sb_q.size()), '0);

    // REQUIRE_FULL instance.
    do_reset();
    for (int c = 0; c < 4; c++) fcycle(1, 0, 16'(c + 1), 0, 0);
    fcycle(0, 0, '0, 1, 0);
    chk("rf_reject", BW'(rej_f), BW'(1));
    chk("rf_not_pending", BW'(pend_f), '0);
    chk("rf_active_unchanged", act_f, '0);
    chk("rf_field_full", BW'(ff_f), BW'(3'b001));
    for (int f = 1; f < 3; f++)
      for (int c = 0; c < 4; c++) fcycle(1, f, 16'(f * 16 + c + 1), 0, 0);
    fcycle(0, 0, '0, 1, 0);
    chk("rf_accept_pending", BW'(pend_f), BW'(1));
    chk("rf_reject_sticky", BW'(rej_f), BW'(1));
    fcycle(0, 0, '0, 0, 1);
    chk("rf_done", BW'(done_f), BW'(1));
    chk("rf_f2c3", BW'(act_f[(8+3)*16 +: 16]), BW'(16'h0024));
    chk("rf_f0c0", BW'(act_f[15:0]), BW'(16'h0001));
    chk("rf_no_overflow", BW'(ovf_f), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
